// File: rtl/pulse_peak_analyzer.sv
// Finds threshold-crossing pulses in a filtered sample stream and reports peak amplitude,
// peak time, start time and width through a single-entry valid/ready output slot.
module pulse_peak_analyzer #(
  parameter int unsigned SIZE_DATA  = 16,
  parameter int unsigned SIZE_TS    = 32,
  parameter int unsigned SIZE_WIDTH = 12,
  parameter int unsigned MAX_WIDTH  = 4095,
  parameter int unsigned HYST       = 4,
  parameter int unsigned DEAD_TIME  = 8,
  parameter int unsigned SIZE_LOST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SIZE_DATA-1:0]  input_data,
  input  logic [SIZE_DATA-1:0]  threshold,
  input  logic                  enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE_DATA-1:0]  out_amplitude,
  output logic [SIZE_TS-1:0]    out_peak_ts,
  output logic [SIZE_TS-1:0]    out_start_ts,
  output logic [SIZE_WIDTH-1:0] out_width,
  output logic                  out_truncated,
  output logic [SIZE_LOST-1:0]  lost_count
);

  localparam int unsigned DeadW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

  typedef enum logic [1:0] {StIdle, StPulse, StReport, StDead} state_e;

  state_e                       state_q;
  logic signed [SIZE_DATA-1:0]  data_q;
  logic signed [SIZE_DATA-1:0]  max_q;
  logic [SIZE_TS-1:0]           ts;
  logic [SIZE_TS-1:0]           ts_q;
  logic [SIZE_TS-1:0]           start_ts_q;
  logic [SIZE_TS-1:0]           max_ts_q;
  logic [SIZE_WIDTH-1:0]        width_q;
  logic                         trunc_q;
  logic [DeadW-1:0]             dead_q;

  logic signed [SIZE_DATA-1:0]  thr_s;
  logic signed [SIZE_DATA:0]    low_level;
  logic signed [SIZE_DATA:0]    data_ext;
  logic                         slot_free;

  // Low level is one bit wider so threshold - HYST never wraps near the negative limit.
  always_comb begin
    thr_s     = $signed(threshold);
    data_ext  = $signed({data_q[SIZE_DATA-1], data_q});
    low_level = $signed({threshold[SIZE_DATA-1], threshold})
                - $signed((SIZE_DATA + 1)'(HYST));
    slot_free = !out_valid || out_ready;
  end

  // ts_q tags data_q with the timestamp of the cycle its sample was presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      ts     <= '0;
      ts_q   <= '0;
    end else begin
      data_q <= $signed(input_data);
      ts     <= ts + 1'b1;
      ts_q   <= ts;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      max_q         <= '0;
      start_ts_q    <= '0;
      max_ts_q      <= '0;
      width_q       <= '0;
      trunc_q       <= 1'b0;
      dead_q        <= '0;
      out_valid     <= 1'b0;
      out_amplitude <= '0;
      out_peak_ts   <= '0;
      out_start_ts  <= '0;
      out_width     <= '0;
      out_truncated <= 1'b0;
      lost_count    <= '0;
    end else begin
      // Accepted record leaves the slot; a load below in the same cycle overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (enable && (data_q >= thr_s)) begin
            state_q    <= StPulse;
            start_ts_q <= ts_q;
            max_q      <= data_q;
            max_ts_q   <= ts_q;
            width_q    <= SIZE_WIDTH'(1);
            trunc_q    <= 1'b0;
          end
        end

        StPulse: begin
          if (data_ext < low_level) begin
            state_q <= StReport;
          end else if (width_q == SIZE_WIDTH'(MAX_WIDTH)) begin
            trunc_q <= 1'b1;
            state_q <= StReport;
          end else begin
            width_q <= width_q + 1'b1;
            if (data_q > max_q) begin
              max_q    <= data_q;
              max_ts_q <= ts_q;
            end
          end
        end

        StReport: begin
          if (slot_free) begin
            out_valid     <= 1'b1;
            out_amplitude <= max_q;
            out_peak_ts   <= max_ts_q;
            out_start_ts  <= start_ts_q;
            out_width     <= width_q;
            out_truncated <= trunc_q;
          end else if (lost_count != {SIZE_LOST{1'b1}}) begin
            lost_count <= lost_count + 1'b1;
          end
          dead_q  <= DeadW'(DEAD_TIME);
          state_q <= (DEAD_TIME == 0) ? StIdle : StDead;
        end

        StDead: begin
          dead_q <= dead_q - 1'b1;
          if (dead_q == DeadW'(1)) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_peak_analyzer.sv
// Bench for pulse_peak_analyzer: directed vector table, hand-written handshake/reset
// sequences, and a random stream checked against an offline pulse-extraction model.
module tb_pulse_peak_analyzer;

  localparam int MAXW = 15;
  localparam int DEAD = 8;
  localparam int HYST = 4;
  localparam int N    = 800;
  localparam int NT   = N + 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_data;
  logic [15:0] threshold;
  logic        enable;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_amplitude;
  logic [31:0] out_peak_ts;
  logic [31:0] out_start_ts;
  logic [11:0] out_width;
  logic        out_truncated;
  logic [15:0] lost_count;

  pulse_peak_analyzer #(
    .SIZE_DATA (16),
    .SIZE_TS   (32),
    .SIZE_WIDTH(12),
    .MAX_WIDTH (MAXW),
    .HYST      (HYST),
    .DEAD_TIME (DEAD),
    .SIZE_LOST (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .threshold    (threshold),
    .enable       (enable),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_amplitude(out_amplitude),
    .out_peak_ts  (out_peak_ts),
    .out_start_ts (out_start_ts),
    .out_width    (out_width),
    .out_truncated(out_truncated),
    .lost_count   (lost_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  typedef struct {
    int thr; int pad; int off; int len;
    int amp; int peak; int start; int width; int trunc; int te;
  } vec_t;

  typedef struct {
    int amp; int pk; int st; int w; int tr; int ld;
  } rec_t;

  int pool [0:36] = '{50, 120, 300, 500, 400, 200, 97, 95,
                      150, 97, 96, 150, 90,
                      -100, -40, -10, -60,
                      200, 200, 200, 200, 200, 200, 200, 200,
                      200, 200, 200, 200, 200, 200, 200, 200,
                      150,
                      100, 96, 95};
  vec_t vecs [6];

  int   smp   [NT];
  bit   rdy_a [NT];
  rec_t exp_q [$];

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // One clock: drive the sample for timestamp 'cyc', then sample outputs 1 ns after the edge.
  task automatic step(input int din, input logic rdy);
    input_data = 16'(din);
    out_ready  = rdy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int thr);
    threshold  = 16'(thr);
    input_data = '0;
    out_ready  = 1'b0;
    enable     = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Offline pulse extraction over the whole sample array, straight from the pulse rules.
  task automatic build_model(input int thr);
    int t;
    int t2;
    int mx;
    int pk;
    int st;
    int w;
    int tr;
    bit done;
    rec_t r;
    t = 0;
    while (t < NT) begin
      if (smp[t] >= thr) begin
        st = t; mx = smp[t]; pk = t; w = 1; tr = 0; done = 0; t2 = t + 1;
        while (!done && t2 < NT) begin
          if (smp[t2] < thr - HYST) done = 1;
          else if (w == MAXW) begin tr = 1; done = 1; end
          else begin
            w++;
            if (smp[t2] > mx) begin mx = smp[t2]; pk = t2; end
          end
          if (!done) t2++;
        end
        if (done) begin
          r = '{amp: mx, pk: pk, st: st, w: w, tr: tr, ld: t2 + 3};
          exp_q.push_back(r);
        end
        t = t2 + 2 + DEAD;
      end else begin
        t++;
      end
    end
  endtask

  initial begin
    vecs[0] = '{100,     0,  0,  8,  500, 13, 11,  6, 0, 17};
    vecs[1] = '{100,     0,  8,  5,  150, 10, 10,  4, 0, 14};
    vecs[2] = '{-50, -1000, 13,  4,  -10, 12, 11,  2, 0, 13};
    vecs[3] = '{100,     0, 17, 16,  200, 10, 10, 15, 1, 25};
    vecs[4] = '{100,     0, 33,  1,  150, 10, 10,  1, 0, 11};
    vecs[5] = '{100,     0, 34,  3,  100, 10, 10,  2, 0, 12};

    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; input_data = '0; threshold = '0;
    #2;
    check("reset_valid", out_valid, 0);
    check("reset_lost", lost_count, 0);
    check("reset_amp", out_amplitude, 0);

    // Directed vector table: sequence starts at ts 10, reader always ready.
    for (int v = 0; v < 6; v++) begin
      int nvalid;
      nvalid = 0;
      do_reset(vecs[v].thr);
      for (int k = 0; k < 45; k++) begin
        int din;
        din    = (k >= 10 && k < 10 + vecs[v].len) ? pool[vecs[v].off + k - 10] : vecs[v].pad;
        enable = (k >= 3);
        step(din, 1'b1);
        if (out_valid) begin
          nvalid++;
          if (nvalid == 1) begin
            check($sformatf("v%0d_latency", v), cyc, vecs[v].te + 3);
            check($sformatf("v%0d_amp", v), $signed(out_amplitude), vecs[v].amp);
            check($sformatf("v%0d_peak_ts", v), out_peak_ts, vecs[v].peak);
            check($sformatf("v%0d_start_ts", v), out_start_ts, vecs[v].start);
            check($sformatf("v%0d_width", v), out_width, vecs[v].width);
            check($sformatf("v%0d_trunc", v), out_truncated, vecs[v].trunc);
          end
        end
      end
      check($sformatf("v%0d_valid_cycles", v), nvalid, 1);
    end

    // Backpressure: first record held, second dropped.
    do_reset(100);
    enable = 1'b1;
    for (int k = 0; k < 46; k++) begin
      step((k == 10) ? 150 : (k == 30) ? 250 : 0, 1'b0);
      if (cyc == 20) begin
        check("bp_valid_early", out_valid, 1);
        check("bp_amp_early", out_amplitude, 150);
      end
    end
    check("bp_valid_held", out_valid, 1);
    check("bp_amp_held", out_amplitude, 150);
    check("bp_start_held", out_start_ts, 10);
    check("bp_lost", lost_count, 1);
    step(0, 1'b1);
    check("bp_valid_drop", out_valid, 0);

    // New record loads in the same cycle the old one is accepted.
    do_reset(100);
    enable = 1'b1;
    for (int k = 0; k < 34; k++) begin
      step((k == 10) ? 150 : (k == 30) ? 250 : 0, (k == 33));
      if (cyc == 33) check("sim_old_amp", out_amplitude, 150);
    end
    check("sim_valid", out_valid, 1);
    check("sim_new_amp", out_amplitude, 250);
    check("sim_new_start", out_start_ts, 30);
    check("sim_lost", lost_count, 0);
    step(0, 1'b1);
    check("sim_valid_drop", out_valid, 0);

    // Truncation and dead time before a new pulse may start.
    begin
      int st_l[$];
      int w_l[$];
      int tr_l[$];
      do_reset(100);
      enable = 1'b1;
      for (int k = 0; k < 60; k++) begin
        step((k >= 10) ? 200 : 0, 1'b1);
        if (out_valid) begin
          st_l.push_back(int'(out_start_ts));
          w_l.push_back(int'(out_width));
          tr_l.push_back(int'(out_truncated));
        end
      end
      check("tr_records", st_l.size(), 2);
      if (st_l.size() >= 2) begin
        check("tr_start0", st_l[0], 10);
        check("tr_width0", w_l[0], 15);
        check("tr_trunc0", tr_l[0], 1);
        check("tr_start1", st_l[1], 35);
        check("tr_trunc1", tr_l[1], 1);
      end
    end

    // Reset while a record is held, one is lost and a third pulse is in progress.
    begin
      int nvalid;
      do_reset(100);
      enable = 1'b1;
      for (int k = 0; k < 56; k++) step((k == 10 || k == 30) ? 150 : (k >= 50) ? 200 : 0, 1'b0);
      check("rst_pre_valid", out_valid, 1);
      check("rst_pre_lost", lost_count, 1);
      #3;
      reset = 1'b1;
      #1;
      check("rst_async_valid", out_valid, 0);
      check("rst_async_lost", lost_count, 0);
      check("rst_async_amp", out_amplitude, 0);
      check("rst_async_start", out_start_ts, 0);
      check("rst_async_width", out_width, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      nvalid = 0;
      for (int k = 0; k < 40; k++) begin
        step(0, 1'b1);
        if (out_valid) nvalid++;
      end
      check("rst_no_record", nvalid, 0);
    end

    // Random stream against the offline model, with a slowly toggling reader.
    begin
      bit hi;
      bit rd;
      bit mv;
      rec_t mrec;
      int mlost;
      hi = 0; rd = 1; mv = 0; mlost = 0;
      mrec = '{amp: 0, pk: 0, st: 0, w: 0, tr: 0, ld: 0};
      for (int k = 0; k < NT; k++) begin
        if ($urandom_range(0, 5) == 0) hi = ~hi;
        if ($urandom_range(0, 9) == 0) rd = ~rd;
        if (k < 5 || k >= N) smp[k] = 0;
        else if (hi) smp[k] = 90 + int'($urandom_range(0, 400));
        else smp[k] = int'($urandom_range(0, 130)) - 60;
        rdy_a[k] = rd;
      end
      exp_q.delete();
      build_model(100);
      do_reset(100);
      for (int k = 0; k < NT; k++) begin
        enable = (k >= 3);
        step(smp[k], rdy_a[k]);
        if (exp_q.size() > 0 && exp_q[0].ld == cyc) begin
          if (!mv || rdy_a[k]) begin
            mv   = 1;
            mrec = exp_q[0];
          end else begin
            mlost++;
          end
          exp_q.delete(0);
        end else if (mv && rdy_a[k]) begin
          mv = 0;
        end
        check($sformatf("rnd_valid@%0d", cyc), out_valid, mv);
        check($sformatf("rnd_lost@%0d", cyc), lost_count, mlost);
        if (mv && out_valid) begin
          check($sformatf("rnd_amp@%0d", cyc), $signed(out_amplitude), mrec.amp);
          check($sformatf("rnd_peak@%0d", cyc), out_peak_ts, mrec.pk);
          check($sformatf("rnd_start@%0d", cyc), out_start_ts, mrec.st);
          check($sformatf("rnd_width@%0d", cyc), out_width, mrec.w);
          check($sformatf("rnd_trunc@%0d", cyc), out_truncated, mrec.tr);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_peak_analyzer.md
Name: pulse_peak_analyzer

Overview:
Consumer end of the filter chain. It takes one filtered sample per clock from a vN_filter output and finds threshold-crossing pulses. For each pulse it measures peak amplitude, peak timestamp, start timestamp and width, then hands the record to a downstream reader through a valid/ready handshake. It sits after the FilterVx instances in the filter top level and closes the exp_sig_gen -> filter -> analysis loop for bench and hardware checks.

Parameters:
SIZE_DATA, 16, width of the signed two's-complement input sample (tied to SIZE_FILTER_DATA at instantiation)
SIZE_TS, 32, width of the free-running timestamp counter
SIZE_WIDTH, 12, width of the pulse-width field
MAX_WIDTH, 4095, pulse width at which the record is forced out and flagged as truncated
HYST, 4, hysteresis subtracted from the threshold for end-of-pulse detection (unsigned)
DEAD_TIME, 8, number of cycles ignored after each report
SIZE_LOST, 16, width of the lost-record counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
input_data  in  SIZE_DATA  signed filtered sample, one per clk
threshold  in  SIZE_DATA  signed trigger level, sampled every cycle
enable  in  1  0 = FSM held in IDLE; timestamp keeps running
out_valid  out  1  record available
out_ready  in  1  reader accepts the record
out_amplitude  out  SIZE_DATA  peak sample value
out_peak_ts  out  SIZE_TS  timestamp of the first occurrence of the peak
out_start_ts  out  SIZE_TS  timestamp of the first sample >= threshold
out_width  out  SIZE_WIDTH  count of in-pulse samples
out_truncated  out  1  pulse hit MAX_WIDTH
lost_count  out  SIZE_LOST  records dropped because the output slot was full (saturating)

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, timestamp 0, data_q 0.
- Input stage:
  - data_q <= input_data every edge.
  - ts <= ts+1 every edge, wraps at 2^SIZE_TS.
  - ts_q <= ts, so ts_q is the timestamp of data_q.
  - All comparisons are signed on data_q.
- Low level = threshold - HYST, computed at SIZE_DATA+1 bits with no wrap.
- FSM states: IDLE, PULSE, REPORT, DEAD.
- IDLE:
  - If enable and data_q >= threshold -> PULSE.
  - On entry to PULSE: start_ts = ts_q, max = data_q, max_ts = ts_q, width = 1.
- PULSE:
  - If data_q < low level -> REPORT; width is not incremented and max is not updated.
  - Else if width == MAX_WIDTH -> REPORT with trunc = 1.
  - Else width++. If data_q > max (strictly greater): max = data_q, max_ts = ts_q. Ties keep the earlier timestamp.
  - enable dropping mid-pulse does not abort the pulse.
- REPORT (exactly one cycle):
  - If the slot is free (out_valid == 0, or out_valid && out_ready this cycle): load all out_* fields and set out_valid = 1 at the next edge.
  - Otherwise the record is dropped and lost_count++, saturating at all-ones.
  - Then -> DEAD with dead counter = DEAD_TIME.
- DEAD: decrement the counter; samples are ignored. -> IDLE on the edge where the counter reaches 0. With DEAD_TIME = 0, go straight to IDLE.
- Output handshake:
  - out_valid holds until the edge where out_ready = 1, then clears, unless a new record loads in that same cycle, in which case out_valid stays 1 with the new data.
  - out_* fields are stable while out_valid = 1 and out_ready = 0.
  - out_ready with out_valid = 0 has no effect.
- Latency:
  - Sample S ending the pulse is captured into data_q at edge E0.
  - FSM enters REPORT at edge E1.
  - out_valid = 1 and fields valid after edge E2.
- Timestamp wrap inside a pulse: fields hold raw wrapped values; width stays correct because it is counted, not subtracted.
- Reset asserted mid-pulse or with out_valid = 1: the record is discarded and lost_count is cleared.

Test Plan:
- Basic pulse. threshold = 100, HYST = 4, out_ready = 1. Drive 50 at ts=10, then 120, 300, 500, 400, 200, 97, 95, then 0. Required: one record with amplitude 500, peak_ts 13, start_ts 11, width 6, truncated 0. out_valid high for 1 cycle, 2 edges after 95 is captured.
- Hysteresis. threshold = 100: 150, 97, 96, 150, 90. Required: a single record, width 4, amplitude 150, peak_ts = ts of the first 150.
- Backpressure. out_ready = 0, two pulses separated by more than DEAD_TIME. Required: the first record is held stable, the second is dropped, lost_count = 1. Raise out_ready: out_valid drops after 1 edge.
- Truncation. MAX_WIDTH = 15, constant 200 with threshold 100. Required: record with width 15, truncated 1. A new pulse starts only after DEAD_TIME = 8 cycles.
- Negative and signed values. threshold = -50, samples -100, -40, -10, -60. Required: amplitude -10, width 2. Samples below -54 end the pulse.
- Reset mid-pulse and simultaneous handshake. Asserting reset during PULSE: all outputs 0 asynchronously and no record after release. A record loading in the same cycle out_ready accepts the old one: out_valid stays 1 with the new fields.
